// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signal bundle shared by alu_arbiter and its neighbours.
// slave is the arbiter's view; master is the requester/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*9-1:0]  req_ins;
    logic [NREQ*DW-1:0] req_srca;
    logic [NREQ*DW-1:0] req_srcb;

    logic [8:0]         alu_ins;
    logic [DW-1:0]      alu_srca;
    logic [DW-1:0]      alu_srcb;
    logic [DW-1:0]      alu_result;
    logic               alu_zero;
    logic               alu_sign;

    logic               resp_valid;
    logic               resp_ready;
    logic [IW-1:0]      resp_id;
    logic [DW-1:0]      resp_data;
    logic               resp_zero;
    logic               resp_sign;
    logic               resp_err;
    logic               busy;

    modport slave (
        input  req_valid, req_ins, req_srca, req_srcb,
        input  alu_result, alu_zero, alu_sign, resp_ready,
        output req_ready, alu_ins, alu_srca, alu_srcb,
        output resp_valid, resp_id, resp_data, resp_zero, resp_sign, resp_err, busy
    );

    modport master (
        output req_valid, req_ins, req_srca, req_srcb,
        output alu_result, alu_zero, alu_sign, resp_ready,
        input  req_ready, alu_ins, alu_srca, alu_srcb,
        input  resp_valid, resp_id, resp_data, resp_zero, resp_sign, resp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: accept one request, run it for one cycle, return a tagged result.
// Define ALU_ARB_RR_EN for round-robin grants; otherwise the lowest valid index wins.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg;
    logic [8:0]     alu_ins_reg;
    logic [DW-1:0]  alu_srca_reg;
    logic [DW-1:0]  alu_srcb_reg;
    logic           resp_valid_reg;
    logic [IW-1:0]  resp_id_reg;
    logic [DW-1:0]  resp_data_reg;
    logic           resp_zero_reg;
    logic           resp_sign_reg;
    logic           resp_err_reg;

    logic           grant_any;
    logic [IW-1:0]  grant_idx;
    logic [NREQ-1:0] ready_vec;

    logic [8:0]     ins_arr  [NREQ];
    logic [DW-1:0]  srca_arr [NREQ];
    logic [DW-1:0]  srcb_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign ins_arr[gi]   = bus.req_ins[9*gi +: 9];
            assign srca_arr[gi]  = bus.req_srca[DW*gi +: DW];
            assign srcb_arr[gi]  = bus.req_srcb[DW*gi +: DW];
            // Gated by rst so a requester is never told "accepted" while reset is held.
            assign ready_vec[gi] = rst && (state_reg == IDLE) && grant_any && (grant_idx == IW'(gi));
        end
    endgenerate

`ifdef ALU_ARB_RR_EN
    logic [IW-1:0] ptr_reg;

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            alu_ins_reg    <= '0;
            alu_srca_reg   <= '0;
            alu_srcb_reg   <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_data_reg  <= '0;
            resp_zero_reg  <= 1'b0;
            resp_sign_reg  <= 1'b0;
            resp_err_reg   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_reg        <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        resp_id_reg <= grant_idx;
`ifdef ALU_ARB_RR_EN
                        ptr_reg <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
`endif
                        // Mux select 11 is reserved: answer with an error and leave the ALU idle.
                        if (ins_arr[grant_idx][8:7] == 2'b11) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_data_reg  <= '0;
                            resp_zero_reg  <= 1'b0;
                            resp_sign_reg  <= 1'b0;
                        end else begin
                            state_reg    <= EXEC;
                            alu_ins_reg  <= ins_arr[grant_idx];
                            alu_srca_reg <= srca_arr[grant_idx];
                            alu_srcb_reg <= srcb_arr[grant_idx];
                        end
                    end
                end
                EXEC: begin
                    resp_data_reg  <= bus.alu_result;
                    resp_zero_reg  <= bus.alu_zero;
                    resp_sign_reg  <= bus.alu_sign;
                    resp_err_reg   <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    alu_ins_reg    <= '0;
                    alu_srca_reg   <= '0;
                    alu_srcb_reg   <= '0;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.alu_ins    = alu_ins_reg;
    assign bus.alu_srca   = alu_srca_reg;
    assign bus.alu_srcb   = alu_srcb_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_id    = resp_id_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_zero  = resp_zero_reg;
    assign bus.resp_sign  = resp_sign_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a grant/result model. Works with or without ALU_ARB_RR_EN.
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   model_ptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in ALU: 00 add, 01 sub, otherwise decoded from funct3.
    function automatic logic [31:0] alu_fn(input logic [8:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (ins[1:0])
            2'b00: r = a + b;
            2'b01: r = a - b;
            default: begin
                case (ins[4:2])
                    3'b111:  r = a & b;
                    3'b110:  r = a | b;
                    3'b100:  r = a ^ b;
                    3'b000:  r = (ins[5] && ins[6]) ? a - b : a + b;
                    default: r = a + b;
                endcase
            end
        endcase
        return r;
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_ins, bus.alu_srca, bus.alu_srcb);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);
    assign bus.alu_sign   = bus.alu_result[31];

    function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef ALU_ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
            if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (v[k]) return k;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int n;
        int idx;
        n = 0;
        idx = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) begin n++; idx = k; end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_req(input int id, input logic [8:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.req_ins[9*id +: 9]    = ins;
        bus.req_srca[DW*id +: DW] = a;
        bus.req_srcb[DW*id +: DW] = b;
    endtask

    typedef struct {
        int          id;
        logic [8:0]  ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        zero;
        logic        sign;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [8:0]  ins_v [NREQ];
        logic [31:0] a_v [NREQ];
        logic [31:0] b_v [NREQ];
        int          g_idx [5];
        int          g_cyc [5];
        int          ng;
        int          g;
        bit          seen;
        bit          done;
        bit          stable;
        int          waited;
        logic [NREQ-1:0] mask;
        logic [31:0] exp_data;
        logic        legal;

        vecs[0] = '{2, 9'b00_0_0_000_00, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 9'b00_0_0_000_01, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1, 1'b0, 1'b0};
        vecs[2] = '{3, 9'b00_0_0_000_01, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{1, 9'b11_0_0_000_00, 32'd1,          32'd2,          32'd0,          1'b0, 1'b0, 1'b1};
        vecs[4] = '{2, 9'b00_0_0_111_10, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{3, 9'b01_0_0_000_00, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};

        // Reset with every requester asserting valid.
        rst = 1'b0;
        bus.req_valid  = '1;
        bus.req_ins    = '0;
        bus.req_srca   = '0;
        bus.req_srcb   = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy",       bus.busy, 0);
        chk("rst_alu",        {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, 0);
        chk("rst_resp_id",    bus.resp_id, 0);
        bus.req_valid = '0;
        rst = 1'b1;
        model_ptr = 0;

        // Directed vectors, one requester at a time, resp_ready held high.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_req(vecs[v].id, vecs[v].ins, vecs[v].a, vecs[v].b);
            bus.req_valid = NREQ'(1) << vecs[v].id;
            #1;
            chk("vec_ready", bus.req_ready, NREQ'(1) << vecs[v].id);
            model_ptr = (vecs[v].id + 1) % NREQ;
            @(negedge clk);
            bus.req_valid = '0;
            if (!vecs[v].err) begin
                chk("vec_alu_ins",  bus.alu_ins, vecs[v].ins);
                chk("vec_alu_ops",  {bus.alu_srca, bus.alu_srcb}, {vecs[v].a, vecs[v].b});
                chk("vec_early_valid", bus.resp_valid, 0);
                @(negedge clk);
                chk("vec_alu_cleared", {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, 0);
                chk("vec_zero", bus.resp_zero, vecs[v].zero);
                chk("vec_sign", bus.resp_sign, vecs[v].sign);
            end else begin
                chk("vec_alu_idle", {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, 0);
            end
            chk("vec_resp_valid", bus.resp_valid, 1);
            chk("vec_resp_id",    bus.resp_id, vecs[v].id);
            chk("vec_resp_data",  bus.resp_data, vecs[v].data);
            chk("vec_resp_err",   bus.resp_err, vecs[v].err);
            $display("vec %0d: id=%0d ins=%b a=%0h b=%0h -> data=%0h err=%0b", v, vecs[v].id,
                     vecs[v].ins, vecs[v].a, vecs[v].b, bus.resp_data, bus.resp_err);
            @(negedge clk);
            chk("vec_resp_done", {bus.resp_valid, bus.busy}, 0);
        end

        // Reset during EXEC: request from requester 2 is dropped, pointer returns to 0.
        @(negedge clk);
        set_req(2, 9'b00_0_0_000_00, 32'd11, 32'd22);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        chk("mid_exec_busy", bus.busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", {bus.busy, bus.resp_valid}, 0);
        chk("mid_rst_alu", {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, 0);
        rst = 1'b1;
        model_ptr = 0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", seen, 0);
        $display("txn reset-in-EXEC: request from id=2 discarded");

        // Contention: all requesters valid, resp_ready high.
        for (int i = 0; i < NREQ; i++) set_req(i, 9'b00_0_0_000_00, 32'(i), 32'd100);
        bus.req_valid = '1;
        bus.resp_ready = 1'b1;
        ng = 0;
        waited = 0;
        while (ng < 5 && waited < 25) begin
            #1;
            if (bus.req_ready != 0) begin
                g_idx[ng] = onehot_idx(bus.req_ready);
                g_cyc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
            waited++;
        end
        bus.req_valid = '0;
        chk("cont_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) begin
            g = model_grant('1);
            model_ptr = (g + 1) % NREQ;
            chk("cont_grant_idx", g_idx[k], g);
            if (k > 0) chk("cont_spacing", g_cyc[k] - g_cyc[k-1], 3);
            $display("txn contention grant %0d -> id=%0d at cycle %0d", k, g_idx[k], g_cyc[k]);
        end
        waited = 0;
        while (bus.busy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("cont_drain", bus.busy, 0);

        // Illegal instruction under back-pressure.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        set_req(1, 9'b11_0_0_000_01, 32'd9, 32'd9);
        bus.req_valid = 4'b0010;
        #1;
        chk("ill_ready", bus.req_ready, 4'b0010);
        model_ptr = 2;
        @(negedge clk);
        bus.req_valid = '0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("ill_alu_ins", bus.alu_ins, 0);
            if (!(bus.resp_valid && bus.resp_err && bus.resp_id == 1 && bus.resp_data == 0)) stable = 1'b0;
            chk("ill_resp_hold", {bus.resp_valid, bus.resp_err, 30'(bus.resp_id), bus.resp_data}, {1'b1, 1'b1, 30'd1, 32'd0});
            @(negedge clk);
        end
        chk("ill_stable", stable, 1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("ill_released", bus.resp_valid, 0);
        $display("txn illegal id=1 held 5 cycles then released");
        bus.resp_ready = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                ins_v[i] = 9'($urandom);
                a_v[i]   = $urandom;
                b_v[i]   = ($urandom_range(0, 7) == 0) ? a_v[i] : $urandom;
                set_req(i, ins_v[i], a_v[i], b_v[i]);
            end
            bus.req_valid = mask;
            #1;
            g = model_grant(mask);
            chk("rnd_ready", bus.req_ready, NREQ'(1) << g);
            model_ptr = (g + 1) % NREQ;
            legal = (ins_v[g][8:7] != 2'b11);
            exp_data = legal ? alu_fn(ins_v[g], a_v[g], b_v[g]) : 32'd0;
            @(negedge clk);
            bus.req_valid = '0;
            if (legal) chk("rnd_alu_drive", {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, {ins_v[g], a_v[g], b_v[g]});
            else       chk("rnd_alu_idle", {bus.alu_ins, bus.alu_srca, bus.alu_srcb}, 0);
            done = 1'b0;
            waited = 0;
            while (!done && waited < 30) begin
                if (bus.resp_valid) begin
                    chk("rnd_resp", {1'b0, bus.resp_err, 30'(bus.resp_id), bus.resp_data}, {1'b0, !legal, 30'(g), exp_data});
                    if (legal) chk("rnd_flags", {bus.resp_zero, bus.resp_sign}, {exp_data == 0, exp_data[31]});
                    bus.resp_ready = 1'($urandom_range(0, 1));
                    done = bus.resp_ready;
                end else begin
                    bus.resp_ready = 1'b0;
                end
                @(negedge clk);
                waited++;
            end
            chk("rnd_handshake", done, 1);
            chk("rnd_idle_after", {bus.resp_valid, bus.busy}, 0);
            bus.resp_ready = 1'b0;
            $display("rnd %0d: mask=%b grant=%0d ins=%b data=%0h err=%0b", it, mask, g, ins_v[g], exp_data, !legal);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single datapath ALU among `NREQ` requesters using a valid/ready request handshake and a registered response channel. Each accepted request carries a 9-bit instruction field and two operands. The block drives them onto the ALU for exactly one cycle, registers the result, and returns it to the requester tagged with the requester's index. It sits between the issue logic of the requesting units and the ALU/decoder pair.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 32, operand/result width
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `req_ins`  in  NREQ*9  per-requester ins; slice i = [9i+8:9i]; fields [8:7] mux select, [6] opb5, [5] funct7b5, [4:2] funct3, [1:0] ALUOp
- `req_srca`, `req_srcb`  in  NREQ*DW  per-requester operands; slice i = [DW*i+DW-1:DW*i]
- `alu_ins`  out  9  instruction to ALU decoder
- `alu_srca`, `alu_srcb`  out  DW  ALU operands
- `alu_result`  in  DW  combinational ALU result
- `alu_zero`, `alu_sign`  in  1  ALU flags
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  response accept
- `resp_id`  out  $clog2(NREQ)  index of the requester being answered
- `resp_data`  out  DW  registered result
- `resp_zero`, `resp_sign`  out  1  registered flags
- `resp_err`  out  1  illegal instruction; the ALU was not used
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, pick grant g by the policy (see Configuration).
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch ins, srca, srcb and id = g.
  - Advance the priority pointer to (g+1) mod NREQ.
  - If `ins[8:7]==2'b11`, go to RESP with `resp_err=1` and `resp_data=0`. Otherwise go to EXEC.
- EXEC:
  - Drive `alu_ins`/`alu_srca`/`alu_srcb` from the latched registers.
  - At the end of the cycle, register `alu_result`, `alu_zero` and `alu_sign` into the response registers, with `resp_err=0`.
  - Next state is RESP.
- RESP:
  - Hold `resp_valid=1`. All `resp_*` outputs stay stable until `resp_ready` is sampled high.
  - On `resp_valid & resp_ready`, go to IDLE.
- Outside EXEC, `alu_ins`, `alu_srca` and `alu_srcb` are 0 (ALUOp=00: add, mux select 00).
- `req_ready` is all-zero outside IDLE.
- A requester must hold `req_valid` and its payload stable until accepted. Dropping `req_valid` before acceptance withdraws the request without effect.
- Requests are not queued. A valid that arrives while busy waits.

## Timing
- Reset (`rst==0` at a rising edge) forces:
  - state IDLE, pointer 0;
  - `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_data=0`, `resp_zero=0`, `resp_sign=0`, `resp_err=0`;
  - `alu_*=0`, `busy=0`.
- Reset has priority over every other event.
- Reset in EXEC or RESP discards the in-flight request; no response is ever produced for it.
- Latency, with acceptance at edge T:
  - normal request: `alu_*` valid during cycle T..T+1, `resp_valid` high after edge T+1;
  - illegal request: `resp_valid` high after edge T.
- Throughput: one request per 3 cycles when `resp_ready` is tied high (IDLE, EXEC, RESP). Back-pressure on `resp_ready` stalls RESP indefinitely.
- Pointer wrap: g = NREQ-1 sets the pointer to 0.
- If the pointer requester and others are valid simultaneously, exactly one grant is issued per IDLE cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin policy. Grant goes to the first valid index at or after the pointer, searching modulo NREQ.
- `ALU_ARB_RR_EN` undefined: fixed priority. The lowest valid index wins. The pointer register is not implemented and does not affect grants.
- All other behaviour is identical in both builds.

## Test plan
- Reset sequence: hold `rst=0` for 2 cycles with `req_valid=4'b1111`. Required: `req_ready=0`, `resp_valid=0`, `busy=0`, `alu_*=0`.
- Single add: requester 2 sends ins=9'b00_0_0_000_00, srca=5, srcb=7, with the ALU model returning the sum. Required:
  - `req_ready[2]` is high in the acceptance cycle;
  - `alu_srca=5` and `alu_srcb=7` for exactly one cycle;
  - 2 edges later `resp_valid=1`, `resp_id=2`, `resp_data=12`, `resp_zero=0`.
- Subtract to zero: ins ALUOp=01, srca=srcb=32'h8000_0000. Required: `resp_data=0`, `resp_zero=1`, `resp_sign=0`.
- Contention, all four requesters valid continuously, `resp_ready=1`. Required grant order:
  - RR build: 0,1,2,3,0;
  - fixed build: 0,0,0,0,0.
  - In both builds, grants are spaced 3 cycles apart.
- Illegal ins and back-pressure: requester 1 sends ins[8:7]=11 while `resp_ready=0` for 5 cycles. Required:
  - `alu_ins` stays 0;
  - `resp_err=1` and `resp_id=1` are held stable for all 5 cycles;
  - one cycle after `resp_ready=1`, `resp_valid` goes to 0.
- Reset mid-EXEC: assert `rst=0` during EXEC. Required: no `resp_valid` pulse for that request, and the pointer returns to 0.
